// File: rtl/traffic_pkg.sv
// Shared types and default constants for the intersection front end and controller.
package traffic_pkg;

  // state      | meaning
  // IDLE       | no car seen, nothing pending
  // PRESENT    | debounced detector high, car on the loop
  // HOLD       | detector fell, presence stretched until the hold timer expires
  // FAULT      | detector stuck high, channel forced active until reset
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2,
    FAULT   = 2'd3
  } chan_state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int HOLD_CYCLES_DEF     = 32;
  localparam int STUCK_CYCLES_DEF    = 1024;

  // Counter width for a count range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One street: synchroniser, debounce, presence FSM and request latch.
//
// state      | meaning
// IDLE       | no car seen, nothing pending
// PRESENT    | debounced detector high; stuck timer running
// HOLD       | detector fell; hold timer counting down to IDLE
// FAULT      | detector stuck high; terminal until reset
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic det_raw,
  input  logic green,
  output logic presence,
  output logic req,
  output logic fault
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam int SW = cnt_width(STUCK_CYCLES);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STUCK_MAX = SW'(STUCK_CYCLES - 1);

  logic          sync1, sync2;
  logic          deb;
  logic [DW-1:0] deb_cnt;
  chan_state_t   state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [SW-1:0] stuck_cnt, stuck_nxt;
  logic          req_nxt;

  // Two-flop synchroniser for the asynchronous loop detector.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= det_raw;
      sync2 <= sync1;
    end
  end

  // Debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else if (sync2 == deb) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_MAX) begin
      deb     <= ~deb;
      deb_cnt <= '0;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  // State, timers and request latch registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      stuck_cnt <= '0;
      req       <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      stuck_cnt <= stuck_nxt;
      req       <= req_nxt;
    end
  end

  // Next-state, timer updates and request set/clear (clear wins over set).
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    stuck_nxt = stuck_cnt;
    case (state)
      IDLE: begin
        if (deb) begin
          state_nxt = PRESENT;
          stuck_nxt = '0;
        end
      end
      PRESENT: begin
        if (!deb) begin
          state_nxt = HOLD;
          hold_nxt  = HOLD_MAX;
        end else if (stuck_cnt == STUCK_MAX) begin
          state_nxt = FAULT;
        end else begin
          stuck_nxt = stuck_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (deb) begin
          state_nxt = PRESENT;
          stuck_nxt = '0;
        end else if (hold_cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase

    req_nxt = req;
    if (state == IDLE && state_nxt == PRESENT) req_nxt = 1'b1;
    if (green) req_nxt = 1'b0;
  end

  assign presence = (state == PRESENT) || (state == HOLD);
  assign fault    = (state == FAULT);

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Two independent detector channels with registered car-waiting and fault outputs.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic det_a_raw,
  input  logic det_b_raw,
  input  logic Ga,
  input  logic Gb,
  output logic Sa,
  output logic Sb,
  output logic fault_a,
  output logic fault_b
);

  logic pres_a, req_a, flt_a;
  logic pres_b, req_b, flt_b;

  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_chan_a (
    .clk     (clk),
    .reset_n (reset_n),
    .det_raw (det_a_raw),
    .green   (Ga),
    .presence(pres_a),
    .req     (req_a),
    .fault   (flt_a)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES),
    .STUCK_CYCLES   (STUCK_CYCLES)
  ) u_chan_b (
    .clk     (clk),
    .reset_n (reset_n),
    .det_raw (det_b_raw),
    .green   (Gb),
    .presence(pres_b),
    .req     (req_b),
    .fault   (flt_b)
  );

  // Registered outputs; a faulted channel keeps requesting service.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Sa      <= 1'b0;
      Sb      <= 1'b0;
      fault_a <= 1'b0;
      fault_b <= 1'b0;
    end else begin
      Sa      <= pres_a | req_a | flt_a;
      Sb      <= pres_b | req_b | flt_b;
      fault_a <= flt_a;
      fault_b <= flt_b;
    end
  end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with default parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_traffic_sensor_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic det_a_raw = 1'b0;
  logic det_b_raw = 1'b0;
  logic Ga = 1'b0;
  logic Gb = 1'b0;
  logic Sa, Sb, fault_a, fault_b;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_sensor_conditioner dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .det_a_raw(det_a_raw),
    .det_b_raw(det_b_raw),
    .Ga       (Ga),
    .Gb       (Gb),
    .Sa       (Sa),
    .Sb       (Sb),
    .fault_a  (fault_a),
    .fault_b  (fault_b)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cyc(2);
    n_checks++;
    if ({Sa, Sb, fault_a, fault_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs: Sa,Sb,fa,fb=%b expected 0000", {Sa, Sb, fault_a, fault_b});
    end
    reset_n = 1'b1;
    cyc(3);
    n_checks++;
    if ({Sa, Sb, fault_a, fault_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle: Sa,Sb,fa,fb=%b expected 0000", {Sa, Sb, fault_a, fault_b});
    end
  endtask

  // Pulse on B with Gb=0: Sb rises 12 cycles after the edge, request survives the hold,
  // a one-cycle Gb clears it.
  task automatic test_clean_pulse();
    Gb = 1'b0;
    det_b_raw = 1'b1;
    cyc(11);
    n_checks++;
    if (Sb !== 1'b0) begin n_fail++; $display("FAIL clean_before_rise: Sb=%b expected 0", Sb); end
    cyc(1);
    n_checks++;
    if (Sb !== 1'b1) begin n_fail++; $display("FAIL clean_rise_12: Sb=%b expected 1", Sb); end
    cyc(8);
    det_b_raw = 1'b0;
    cyc(50);
    n_checks++;
    if (Sb !== 1'b1) begin n_fail++; $display("FAIL clean_req_latched: Sb=%b expected 1", Sb); end
    n_checks++;
    if (Sa !== 1'b0) begin n_fail++; $display("FAIL clean_a_independent: Sa=%b expected 0", Sa); end
    Gb = 1'b1;
    cyc(1);
    Gb = 1'b0;
    n_checks++;
    if (Sb !== 1'b1) begin n_fail++; $display("FAIL clean_clear_latency: Sb=%b expected 1", Sb); end
    cyc(1);
    n_checks++;
    if (Sb !== 1'b0) begin n_fail++; $display("FAIL clean_served: Sb=%b expected 0", Sb); end
    cyc(5);
  endtask

  task automatic test_bounce();
    Ga = 1'b0;
    for (int i = 0; i < 50; i++) begin
      det_a_raw = ((i / 3) % 2 == 0);
      cyc(1);
      n_checks++;
      if (Sa !== 1'b0) begin n_fail++; $display("FAIL bounce_cycle_%0d: Sa=%b expected 0", i, Sa); end
    end
    det_a_raw = 1'b0;
    cyc(15);
    n_checks++;
    if (Sa !== 1'b0) begin n_fail++; $display("FAIL bounce_after: Sa=%b expected 0", Sa); end
  endtask

  // Car arrives while A is already green: presence plus hold only, no request.
  task automatic test_served_green();
    Ga = 1'b1;
    det_a_raw = 1'b1;
    cyc(12);
    n_checks++;
    if (Sa !== 1'b1) begin n_fail++; $display("FAIL green_rise: Sa=%b expected 1", Sa); end
    cyc(8);
    det_a_raw = 1'b0;
    cyc(43);
    n_checks++;
    if (Sa !== 1'b1) begin n_fail++; $display("FAIL green_hold_end: Sa=%b expected 1", Sa); end
    cyc(1);
    n_checks++;
    if (Sa !== 1'b0) begin n_fail++; $display("FAIL green_fall: Sa=%b expected 0", Sa); end
    Ga = 1'b0;
    cyc(6);
    n_checks++;
    if (Sa !== 1'b0) begin n_fail++; $display("FAIL green_no_req: Sa=%b expected 0", Sa); end
  endtask

  // Gb high on exactly the cycle B enters PRESENT: clear wins, no request latched.
  task automatic test_collision();
    Gb = 1'b0;
    det_b_raw = 1'b1;
    cyc(10);
    Gb = 1'b1;
    cyc(1);
    Gb = 1'b0;
    cyc(1);
    n_checks++;
    if (Sb !== 1'b1) begin n_fail++; $display("FAIL collide_presence: Sb=%b expected 1", Sb); end
    cyc(8);
    det_b_raw = 1'b0;
    cyc(43);
    n_checks++;
    if (Sb !== 1'b1) begin n_fail++; $display("FAIL collide_hold_end: Sb=%b expected 1", Sb); end
    cyc(1);
    n_checks++;
    if (Sb !== 1'b0) begin n_fail++; $display("FAIL collide_no_req: Sb=%b expected 0", Sb); end
    cyc(5);
  endtask

  task automatic test_stuck();
    Gb = 1'b0;
    det_b_raw = 1'b1;
    cyc(1035);
    n_checks++;
    if (fault_b !== 1'b0) begin n_fail++; $display("FAIL stuck_early: fault_b=%b expected 0", fault_b); end
    cyc(1);
    n_checks++;
    if (fault_b !== 1'b1) begin n_fail++; $display("FAIL stuck_detect: fault_b=%b expected 1", fault_b); end
    cyc(64);
    det_b_raw = 1'b0;
    cyc(60);
    n_checks++;
    if ({fault_b, Sb} !== 2'b11) begin
      n_fail++;
      $display("FAIL stuck_sticky: fault_b,Sb=%b expected 11", {fault_b, Sb});
    end
    n_checks++;
    if ({fault_a, Sa} !== 2'b00) begin
      n_fail++;
      $display("FAIL stuck_a_independent: fault_a,Sa=%b expected 00", {fault_a, Sa});
    end
  endtask

  // Reset asserted while A is in HOLD with a pending request.
  task automatic test_reset_mid_hold();
    Ga = 1'b0;
    det_a_raw = 1'b1;
    cyc(20);
    det_a_raw = 1'b0;
    cyc(25);
    n_checks++;
    if (Sa !== 1'b1) begin n_fail++; $display("FAIL midhold_active: Sa=%b expected 1", Sa); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({Sa, Sb, fault_a, fault_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midhold_async_reset: Sa,Sb,fa,fb=%b expected 0000", {Sa, Sb, fault_a, fault_b});
    end
    cyc(2);
    reset_n = 1'b1;
    cyc(40);
    n_checks++;
    if ({Sa, Sb, fault_a, fault_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midhold_after_release: Sa,Sb,fa,fb=%b expected 0000", {Sa, Sb, fault_a, fault_b});
    end
  endtask

  initial begin
    test_reset();
    test_clean_pulse();
    test_bounce();
    test_served_green();
    test_collision();
    test_stuck();
    test_reset_mid_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
